// File: rtl/clock_alarm.sv
// Alarm stage behind the time-of-day counter: settable hour:minute alarm,
// bounded ring with limited snoozes, stop, and a beeping buzzer output.

module clock_alarm_btn #(
  parameter int DEB_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);
  localparam int CW = $clog2(DEB_CYC + 1);

  logic [2:0]    sync_q, sync_d;
  logic [CW-1:0] deb_q, deb_d;

  // sync_q[1:0] is the metastability pair, sync_q[2] holds the previous level
  always_comb begin
    sync_d = {sync_q[1:0], btn_n};
    press  = sync_q[2] & ~sync_q[1] & (deb_q == '0);
    deb_d  = deb_q;
    if (press)             deb_d = CW'(DEB_CYC);
    else if (deb_q != '0)  deb_d = deb_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b111;
      deb_q  <= '0;
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
    end
  end
endmodule

module clock_alarm #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int DEB_CYC    = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_1s,
  input  logic [16:0] time_s,
  input  logic        alarm_en,
  input  logic        set_m_n,
  input  logic        set_h_n,
  input  logic        snooze_n,
  input  logic        stop_n,
  output logic [16:0] alarm_time,
  output logic        ringing,
  output logic        snoozing,
  output logic        buzz,
  output logic [1:0]  snooze_left
);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam logic [8:0] RING_LAST = 9'(RING_SEC - 1);
  localparam logic [8:0] SNZ_LAST  = 9'(SNOOZE_SEC - 1);
  localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

  // button order: 0 set_m, 1 set_h, 2 snooze, 3 stop
  logic [3:0] btn_n, press;
  assign btn_n = {stop_n, snooze_n, set_h_n, set_m_n};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    clock_alarm_btn #(.DEB_CYC(DEB_CYC)) u_btn (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_n[i]),
      .press (press[i])
    );
  end

  state_t      state_q, state_d;
  logic [8:0]  sec_cnt_q, sec_cnt_d;
  logic [1:0]  left_q, left_d;
  logic [4:0]  hour_q, hour_d;
  logic [5:0]  min_q, min_d;
  logic [16:0] time_q, time_d;
  logic        clk_1s_q, clk_1s_d;
  logic        tick, match;

  assign alarm_time = 17'(hour_q) * 17'd3600 + 17'(min_q) * 17'd60;
  assign tick  = clk_1s & ~clk_1s_q;
  // Only a change of time_s onto the alarm fires, never an edit of the alarm
  assign match = (time_s == alarm_time) && (time_q != alarm_time);

  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    left_d    = left_q;
    hour_d    = hour_q;
    min_d     = min_q;
    time_d    = time_s;
    clk_1s_d  = clk_1s;

    if (press[0]) min_d  = (min_q  == 6'd59) ? 6'd0 : min_q + 6'd1;
    if (press[1]) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;

    if (!alarm_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (match) begin
          state_d   = RING;
          sec_cnt_d = '0;
          left_d    = SNZ_MAX;
        end
        RING: begin
          if (press[3]) begin
            state_d = IDLE;
          end else if (press[2] && left_q != 2'd0) begin
            state_d   = SNOOZE;
            sec_cnt_d = '0;
            left_d    = left_q - 2'd1;
          end else if (tick) begin
            if (sec_cnt_q == RING_LAST) state_d = IDLE;
            else                        sec_cnt_d = sec_cnt_q + 9'd1;
          end
        end
        SNOOZE: begin
          if (press[3]) begin
            state_d = IDLE;
          end else if (tick) begin
            if (sec_cnt_q == SNZ_LAST) begin
              state_d   = RING;
              sec_cnt_d = '0;
            end else begin
              sec_cnt_d = sec_cnt_q + 9'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sec_cnt_q <= '0;
      left_q    <= SNZ_MAX;
      hour_q    <= 5'd7;
      min_q     <= 6'd0;
      time_q    <= time_s;
      clk_1s_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_cnt_q <= sec_cnt_d;
      left_q    <= left_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      time_q    <= time_d;
      clk_1s_q  <= clk_1s_d;
    end
  end

  assign ringing     = (state_q == RING);
  assign snoozing    = (state_q == SNOOZE);
  assign buzz        = ringing & clk_1s;
  assign snooze_left = left_q;
endmodule

// File: tb/tb_clock_alarm.sv
// Randomized and directed checks of clock_alarm against a seconds/minutes
// level behavioural model of the alarm.

module tb_clock_alarm;
  localparam int DEB  = 120;
  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int MAXS = 3;

  logic        clk = 0, rst = 1, clk_1s = 0, alarm_en = 0;
  logic [16:0] time_s = 0;
  logic        set_m_n = 1, set_h_n = 1, snooze_n = 1, stop_n = 1;
  logic [16:0] alarm_time;
  logic        ringing, snoozing, buzz;
  logic [1:0]  snooze_left;

  clock_alarm #(.RING_SEC(RING), .SNOOZE_SEC(SNZ), .MAX_SNOOZE(MAXS), .DEB_CYC(DEB)) dut (
    .clk(clk), .rst(rst), .clk_1s(clk_1s), .time_s(time_s), .alarm_en(alarm_en),
    .set_m_n(set_m_n), .set_h_n(set_h_n), .snooze_n(snooze_n), .stop_n(stop_n),
    .alarm_time(alarm_time), .ringing(ringing), .snoozing(snoozing), .buzz(buzz),
    .snooze_left(snooze_left)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc_no = 0;

  // Model: mode 0 idle, 1 ringing, 2 snoozing; m_rem = seconds left in phase
  int       m_mode, m_rem, m_left, m_hour, m_min, m_prev_t;
  bit       m_prev_1s, m_tick;
  bit [2:0] m_hist[4];
  int       m_last_acc[4];

  function automatic int m_at();
    return m_hour * 3600 + m_min * 60;
  endfunction

  function automatic logic [21:0] exp_vec();
    return {m_mode == 1, m_mode == 2, (m_mode == 1) && clk_1s, 2'(m_left), 17'(m_at())};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {ringing, snoozing, buzz, snooze_left, alarm_time};
  endfunction

  task automatic model_step();
    bit raw[4], acc[4];
    bit match;
    int at;
    raw = '{set_m_n, set_h_n, snooze_n, stop_n};
    if (rst) begin
      m_mode = 0; m_rem = 0; m_left = MAXS; m_hour = 7; m_min = 0;
      m_prev_t = time_s; m_prev_1s = 0; m_tick = 0;
      for (int i = 0; i < 4; i++) begin m_hist[i] = 3'b111; m_last_acc[i] = -100000; end
      return;
    end
    // a press is the raw level falling between 3 and 2 edges ago, then locked out
    for (int i = 0; i < 4; i++) begin
      acc[i] = m_hist[i][2] && !m_hist[i][1] && (cyc_no - m_last_acc[i] > DEB);
      if (acc[i]) m_last_acc[i] = cyc_no;
      m_hist[i] = {m_hist[i][1:0], raw[i]};
    end
    at     = m_at();
    match  = (int'(time_s) == at) && (m_prev_t != at);
    m_tick = clk_1s && !m_prev_1s;
    if (!alarm_en) m_mode = 0;
    else if (m_mode == 0) begin
      if (match) begin m_mode = 1; m_rem = RING; m_left = MAXS; end
    end else if (m_mode == 1) begin
      if (acc[3]) m_mode = 0;
      else if (acc[2] && m_left > 0) begin m_mode = 2; m_rem = SNZ; m_left--; end
      else if (m_tick) begin m_rem--; if (m_rem == 0) m_mode = 0; end
    end else begin
      if (acc[3]) m_mode = 0;
      else if (m_tick) begin m_rem--; if (m_rem == 0) begin m_mode = 1; m_rem = RING; end end
    end
    if (acc[0]) m_min  = (m_min + 1) % 60;
    if (acc[1]) m_hour = (m_hour + 1) % 24;
    m_prev_t  = time_s;
    m_prev_1s = clk_1s;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    cyc_no++;
    #1 clk_1s = (cyc_no % 8) >= 4;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input int b, input int low);
    case (b) 0: set_m_n = 0; 1: set_h_n = 0; 2: snooze_n = 0; default: stop_n = 0; endcase
    idle(low);
    set_m_n = 1; set_h_n = 1; snooze_n = 1; stop_n = 1;
  endtask

  task automatic do_reset();
    rst = 1; idle(2); rst = 0; idle(2);
  endtask

  task automatic test_reset();
    rst = 1; alarm_en = 0; time_s = 0; idle(3);
    n_cmp++;
    if (dut_vec() !== {1'b0, 1'b0, 1'b0, 2'd3, 17'd25200}) begin
      n_bad++; $display("FAIL reset_vals got=%h want=%h", dut_vec(), {1'b0, 1'b0, 1'b0, 2'd3, 17'd25200});
    end
    rst = 0; idle(2);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL post_reset got=%h want=%h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_trigger();
    int ticks = 0, buzz_hi = 0, buzz_lo = 0;
    bit done = 0;
    alarm_en = 1; time_s = 25199; idle(3);
    n_cmp++;
    if (ringing !== 1'b0) begin n_bad++; $display("FAIL pre_trigger ringing=%b want 0", ringing); end
    time_s = 25200; step();
    n_cmp++;
    if (ringing !== 1'b1 || alarm_time !== 17'd25200) begin
      n_bad++; $display("FAIL trigger ringing=%b at=%0d want 1/25200", ringing, alarm_time);
    end
    for (int i = 0; i < 1000 && !done; i++) begin
      step();
      if (m_tick) ticks++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL ring_run cyc=%0d got=%h want=%h", cyc_no, dut_vec(), exp_vec()); end
      if (ringing === 1'b1) begin if (buzz) buzz_hi++; else buzz_lo++; end
      if (ringing === 1'b0) done = 1;
    end
    n_cmp++;
    if (!done || ticks != RING) begin n_bad++; $display("FAIL ring_len ticks=%0d done=%0d want %0d", ticks, done, RING); end
    n_cmp++;
    if (buzz_hi == 0 || buzz_lo == 0) begin n_bad++; $display("FAIL buzz_toggle hi=%0d lo=%0d want both >0", buzz_hi, buzz_lo); end
  endtask

  task automatic test_snooze();
    bit back;
    do_reset();
    alarm_en = 1; time_s = 25199; idle(2); time_s = 25200; step();
    for (int k = 0; k < 4; k++) begin
      idle(5); press(2, 4); idle(6);
      n_cmp++;
      if (snoozing !== (k < 3) || snooze_left !== 2'((k < 3) ? 2 - k : 0) || dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL snooze_%0d snoozing=%b left=%0d want %0d/%0d", k, snoozing, snooze_left, k < 3, (k < 3) ? 2 - k : 0);
      end
      if (k < 3) begin
        back = 0;
        for (int i = 0; i < SNZ * 8 + 50 && !back; i++) begin
          step();
          if (ringing === 1'b1) back = 1;
        end
        n_cmp++;
        if (!back || dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL snooze_return_%0d got=%h want=%h", k, dut_vec(), exp_vec()); end
      end
    end
    press(3, 4); idle(6);
    n_cmp++;
    if (ringing !== 1'b0 || snoozing !== 1'b0) begin n_bad++; $display("FAIL stop ringing=%b snoozing=%b want 0/0", ringing, snoozing); end
  endtask

  task automatic test_set();
    do_reset();
    alarm_en = 1; time_s = 50000;
    for (int i = 0; i < 17; i++) begin press(1, 3); idle(130); end
    n_cmp++;
    if (alarm_time !== 17'd0) begin n_bad++; $display("FAIL hour_wrap at=%0d want 0", alarm_time); end
    for (int i = 0; i < 59; i++) begin press(0, 3); idle(130); end
    n_cmp++;
    if (alarm_time !== 17'd3540) begin n_bad++; $display("FAIL min_59 at=%0d want 3540", alarm_time); end
    press(0, 3); idle(130);
    n_cmp++;
    if (alarm_time !== 17'd0 || dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL min_wrap at=%0d want 0", alarm_time); end
    time_s = 86399; idle(2); time_s = 0; step();
    n_cmp++;
    if (ringing !== 1'b1) begin n_bad++; $display("FAIL midnight ringing=%b want 1", ringing); end
    rst = 1; step();
    n_cmp++;
    if (ringing !== 1'b0 || alarm_time !== 17'd25200) begin
      n_bad++; $display("FAIL reset_mid_ring ringing=%b at=%0d want 0/25200", ringing, alarm_time);
    end
    rst = 0; idle(2);
  endtask

  task automatic test_bounce();
    do_reset();
    alarm_en = 1; time_s = 50000;
    for (int i = 0; i < 5; i++) begin set_m_n = 0; idle(5); set_m_n = 1; idle(5); end
    idle(200);
    n_cmp++;
    if (alarm_time !== 17'd25260) begin n_bad++; $display("FAIL bounce at=%0d want 25260", alarm_time); end
  endtask

  task automatic test_en_stop();
    bit rang = 0;
    do_reset();
    alarm_en = 1; time_s = 25199; idle(2); time_s = 25200; step();
    press(2, 4); idle(6);
    n_cmp++;
    if (snoozing !== 1'b1) begin n_bad++; $display("FAIL en_snooze snoozing=%b want 1", snoozing); end
    alarm_en = 0; step();
    n_cmp++;
    if (snoozing !== 1'b0 || ringing !== 1'b0) begin n_bad++; $display("FAIL en_low snoozing=%b ringing=%b want 0/0", snoozing, ringing); end
    alarm_en = 1; time_s = 25199; idle(130); time_s = 25200; step();
    n_cmp++;
    if (ringing !== 1'b1) begin n_bad++; $display("FAIL retrigger ringing=%b want 1", ringing); end
    stop_n = 0; snooze_n = 0; idle(4); stop_n = 1; snooze_n = 1; idle(4);
    n_cmp++;
    if (ringing !== 1'b0 || snoozing !== 1'b0 || snooze_left !== 2'd3) begin
      n_bad++; $display("FAIL stop_and_snooze ringing=%b snoozing=%b left=%0d want 0/0/3", ringing, snoozing, snooze_left);
    end
    time_s = 25260; idle(130);
    press(0, 3);
    for (int i = 0; i < 20; i++) begin step(); if (ringing === 1'b1) rang = 1; end
    n_cmp++;
    if (rang || alarm_time !== 17'd25260) begin n_bad++; $display("FAIL static_edit rang=%0d at=%0d want 0/25260", rang, alarm_time); end
  endtask

  task automatic test_random();
    int r, prints = 0;
    do_reset();
    alarm_en = 1;
    for (int i = 0; i < 20000; i++) begin
      rst = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 799) == 0) alarm_en = ~alarm_en;
      r = $urandom_range(0, 99);
      if (r < 3)       time_s = 17'(m_at());
      else if (r < 6)  time_s = 17'((m_at() + 86399) % 86400);
      else if (r < 8)  time_s = 17'($urandom_range(0, 86399));
      else if (r < 18) time_s = 17'((int'(time_s) + 1) % 86400);
      if (set_m_n)  set_m_n  = ($urandom_range(0, 299) != 0);  else set_m_n  = ($urandom_range(0, 2) == 0);
      if (set_h_n)  set_h_n  = ($urandom_range(0, 299) != 0);  else set_h_n  = ($urandom_range(0, 2) == 0);
      if (snooze_n) snooze_n = ($urandom_range(0, 399) != 0);  else snooze_n = ($urandom_range(0, 2) == 0);
      if (stop_n)   stop_n   = ($urandom_range(0, 1499) != 0); else stop_n   = ($urandom_range(0, 2) == 0);
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        if (prints < 10) begin prints++; $display("FAIL random cyc=%0d got=%h want=%h", cyc_no, dut_vec(), exp_vec()); end
      end
    end
    rst = 0; set_m_n = 1; set_h_n = 1; snooze_n = 1; stop_n = 1;
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_snooze();
    test_set();
    test_bounce();
    test_en_stop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
